// File: rtl/datamem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// datamem_arbiter_if: one requester port (req/gnt command, ack/rdata completion). Rev 1.0
interface datamem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wd;
  logic                     gnt;
  logic                     ack;
  logic [DATA_WIDTH-1:0]    rdata;

  modport master (output req, we, addr, wd, input gnt, ack, rdata);
  modport slave  (input req, we, addr, wd, output gnt, ack, rdata);
endinterface
`default_nettype wire

// File: rtl/datamem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// datamem_arbiter: shares a single-port data memory between two requesters, one access per 2 cycles.
// Tie-break is round-robin when DATAMEM_ARB_RR_EN is defined, otherwise fixed priority to port 0. Rev 1.0
module datamem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  datamem_arbiter_if.slave         m0,
  datamem_arbiter_if.slave         m1,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd,
  output logic                     busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_nx;
  logic                     cmd_port;
  logic                     cmd_we;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]    cmd_wd;
  logic                     ack0;
  logic                     ack1;
  logic [DATA_WIDTH-1:0]    rdata0;
  logic [DATA_WIDTH-1:0]    rdata1;
  logic                     grant;
  logic                     win;
  logic                     gnt0;
  logic                     gnt1;
`ifdef DATAMEM_ARB_RR_EN
  logic                     last_win;
`endif

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    win      = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state)
      IDLE: begin
        if (m0.req && m1.req) begin
`ifdef DATAMEM_ARB_RR_EN
          win = ~last_win;
`else
          win = 1'b0;
`endif
        end else begin
          win = ~m0.req;
        end
        grant = m0.req | m1.req;
        if (grant) begin
          state_nx = ACCESS;
          gnt0     = ~win;
          gnt1     = win;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_port <= 1'b0;
      cmd_we   <= 1'b0;
      cmd_addr <= '0;
      cmd_wd   <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
`ifdef DATAMEM_ARB_RR_EN
      last_win <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant) begin
        cmd_port <= win;
        cmd_we   <= win ? m1.we   : m0.we;
        cmd_addr <= win ? m1.addr : m0.addr;
        cmd_wd   <= win ? m1.wd   : m0.wd;
`ifdef DATAMEM_ARB_RR_EN
        last_win <= win;
`endif
      end
      // Completion: only the port that owns the command sees ack/rdata change.
      if (state == ACCESS) begin
        if (cmd_port) begin
          ack1 <= 1'b1;
          if (!cmd_we) rdata1 <= mem_rd;
        end else begin
          ack0 <= 1'b1;
          if (!cmd_we) rdata0 <= mem_rd;
        end
      end
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.ack    = ack0;
  assign m1.ack    = ack1;
  assign m0.rdata  = rdata0;
  assign m1.rdata  = rdata1;
  assign busy      = (state == ACCESS);
  assign mem_wr_en = (state == ACCESS) && cmd_we;
  assign mem_addr  = cmd_addr;
  assign mem_wd    = cmd_wd;

endmodule
`default_nettype wire

// File: tb/tb_datamem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_datamem_arbiter: directed and random requester traffic checked against a cycle-scheduled transaction model. Rev 1.0
module tb_datamem_arbiter;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        busy;
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  datamem_arbiter_if m0_if ();
  datamem_arbiter_if m1_if ();

  datamem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .busy      (busy)
  );

  assign mem_rd = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wd;

  // Expectations are scheduled per absolute cycle from the grant cycle N:
  // access in N+1, ack (and read data) in N+2.
  int          cyc;
  int          n_checks;
  int          n_fail;
  bit          last_win;
  bit          sched_busy [MAXC];
  bit          sched_we   [MAXC];
  bit          sched_ack0 [MAXC];
  bit          sched_ack1 [MAXC];
  bit          sched_rd   [MAXC];
  logic [31:0] sched_val  [MAXC];
  logic [31:0] exp_addr, exp_wd, exp_rdata0, exp_rdata1;
  bit          granted0, granted1;
  logic [1:0]  obs_gnt;

  task check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  task model_reset();
    for (int i = 0; i < MAXC; i++) begin
      sched_busy[i] = 0; sched_we[i] = 0; sched_ack0[i] = 0;
      sched_ack1[i] = 0; sched_rd[i] = 0; sched_val[i] = '0;
    end
    last_win = 1; exp_addr = '0; exp_wd = '0; exp_rdata0 = '0; exp_rdata1 = '0;
    granted0 = 0; granted1 = 0; cyc = 0;
  endtask

  // Called 1ns after a rising edge with inputs already driven; returns 1ns after the next one.
  task cycle();
    bit b, g, w, we;
    logic [31:0] a, d;
    #3;
    b = sched_busy[cyc];
    if (sched_ack0[cyc] && sched_rd[cyc]) exp_rdata0 = sched_val[cyc];
    if (sched_ack1[cyc] && sched_rd[cyc]) exp_rdata1 = sched_val[cyc];
    g = 0; w = 0; granted0 = 0; granted1 = 0;
    if (!b && (m0_if.req || m1_if.req)) begin
      g = 1;
      if (m0_if.req && m1_if.req) begin
`ifdef DATAMEM_ARB_RR_EN
        w = !last_win;
`else
        w = 0;
`endif
      end else begin
        w = m1_if.req;
      end
    end
    obs_gnt = {m1_if.gnt, m0_if.gnt};
    check("gnt0",      m0_if.gnt,   g && !w);
    check("gnt1",      m1_if.gnt,   g && w);
    check("busy",      busy,        b);
    check("mem_wr_en", mem_wr_en,   b && sched_we[cyc]);
    check("mem_addr",  mem_addr,    exp_addr);
    check("mem_wd",    mem_wd,      exp_wd);
    check("ack0",      m0_if.ack,   sched_ack0[cyc]);
    check("ack1",      m1_if.ack,   sched_ack1[cyc]);
    check("rdata0",    m0_if.rdata, exp_rdata0);
    check("rdata1",    m1_if.rdata, exp_rdata1);
    if (g) begin
      last_win = w;
      we = w ? m1_if.we   : m0_if.we;
      a  = w ? m1_if.addr : m0_if.addr;
      d  = w ? m1_if.wd   : m0_if.wd;
      granted0 = !w; granted1 = w;
      sched_busy[cyc+1] = 1;
      sched_we[cyc+1]   = we;
      if (w) sched_ack1[cyc+2] = 1;
      else   sched_ack0[cyc+2] = 1;
      sched_rd[cyc+2]  = !we;
      sched_val[cyc+2] = ref_mem[a[7:0]];
      exp_addr = a;
      exp_wd   = d;
    end
    @(posedge clk);
    if (b && sched_we[cyc]) ref_mem[exp_addr[7:0]] = exp_wd;
    cyc++;
    #1;
  endtask

  task drive(input int pct);
    if (granted0) m0_if.req = 0;
    if (!m0_if.req && $urandom_range(99) < pct) begin
      m0_if.req = 1; m0_if.we = 1'($urandom_range(1)); m0_if.addr = $urandom; m0_if.wd = $urandom;
    end
    if (granted1) m1_if.req = 0;
    if (!m1_if.req && $urandom_range(99) < pct) begin
      m1_if.req = 1; m1_if.we = 1'($urandom_range(1)); m1_if.addr = $urandom; m1_if.wd = $urandom;
    end
  endtask

  initial begin
    int k;
    int wins [4];
    n_checks = 0; n_fail = 0;
    rst = 1;
    m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wd = '0;
    m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wd = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   busy,        1'b0);
    check("rst_wr_en",  mem_wr_en,   1'b0);
    check("rst_addr",   mem_addr,    32'h0);
    check("rst_rdata1", m1_if.rdata, 32'h0);
    rst = 0;

    // Idle: nothing happens for 10 cycles.
    repeat (10) cycle();

    // Single read from port 0.
    mem[8'hFF] = 32'h12345; ref_mem[8'hFF] = 32'h12345;
    m0_if.req = 1; m0_if.we = 0; m0_if.addr = 32'hFF;
    cycle();
    m0_if.req = 0;
    repeat (3) cycle();

    // Single write from port 1.
    m1_if.req = 1; m1_if.we = 1; m1_if.addr = 32'h10; m1_if.wd = 32'hDEADBEEF;
    cycle();
    m1_if.req = 0;
    repeat (3) cycle();

    // Contention: both ports request continuously.
    m0_if.req = 1; m0_if.we = 0; m0_if.addr = $urandom;
    m1_if.req = 1; m1_if.we = 0; m1_if.addr = $urandom;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_gnt != 2'b00 && k < 4) begin
        wins[k] = int'(obs_gnt[1]);
        k++;
      end
      if (granted0) m0_if.addr = $urandom;
      if (granted1) m1_if.addr = $urandom;
    end
    check("cont_count", 64'(k), 64'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef DATAMEM_ARB_RR_EN
      check("cont_winner", 64'(wins[i]), 64'(i % 2));
`else
      check("cont_winner", 64'(wins[i]), 64'd0);
`endif
    end
    m0_if.req = 0; m1_if.req = 0;
    repeat (3) cycle();

    // Back-to-back write then read of the same word from port 0.
    m0_if.req = 1; m0_if.we = 1; m0_if.addr = 32'h20; m0_if.wd = 32'h5;
    cycle();
    m0_if.we = 0;
    cycle();
    cycle();
    m0_if.req = 0;
    cycle();
    #2;
    check("b2b_ack",   m0_if.ack,   1'b1);
    check("b2b_rdata", m0_if.rdata, 32'h5);
    cycle();
    repeat (2) cycle();

    // Reset in the middle of a write access.
    m1_if.req = 1; m1_if.we = 1; m1_if.addr = 32'h30; m1_if.wd = 32'hAA;
    cycle();
    m1_if.req = 0;
    #2;
    rst = 1;
    #1;
    check("rst_mid_wr_en", mem_wr_en, 1'b0);
    check("rst_mid_busy",  busy,      1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_mid_ack1", m1_if.ack, 1'b0);
    end
    rst = 0;
    model_reset();
    repeat (3) cycle();
    check("rst_mid_nowrite", mem[8'h30], ref_mem[8'h30]);
    m0_if.req = 1; m0_if.we = 0; m0_if.addr = $urandom;
    m1_if.req = 1; m1_if.we = 0; m1_if.addr = $urandom;
    cycle();
    check("rst_tie_port0", obs_gnt, 2'b01);
    if (granted0) m0_if.req = 0;
    m1_if.req = 0;
    repeat (3) cycle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(40);
      cycle();
    end
    m0_if.req = 0; m1_if.req = 0;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter that shares the single-port data memory between two requesters: port 0 is the CPU load/store path and port 1 is a secondary master (debug loader or DMA). It accepts one request per two cycles, using a req/gnt handshake with round-robin selection. It registers the winning command and drives the memory's write enable, address and write data for exactly one access cycle. It returns an acknowledge, plus registered read data for loads, to the requester that won.

## Interface
- ADDRESS_WIDTH, 32, width of request and memory address.
- DATA_WIDTH, 32, width of write and read data.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- m0_req / m1_req  in  1  request valid; held with its command until the matching gnt.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDRESS_WIDTH  word address.
- m0_wd / m1_wd  in  DATA_WIDTH  write data.
- m0_gnt / m1_gnt  out  1  combinational accept pulse; the request transfers when req && gnt.
- m0_ack / m1_ack  out  1  one-cycle completion pulse, for both reads and writes.
- m0_rdata / m1_rdata  out  DATA_WIDTH  registered read data; valid with ack on reads, held otherwise.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  ADDRESS_WIDTH  memory address.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  memory read data; combinational from mem_addr.
- busy  out  1  high when the FSM is in ACCESS.

## Operation
- FSM states: IDLE and ACCESS.
- IDLE:
  - If any req is high, select a winner and assert that port's gnt only.
  - Latch {port id, we, addr, wd} into the command register.
  - Go to ACCESS.
  - With no req, stay in IDLE and drive no gnt.
- ACCESS:
  - mem_addr/mem_wd come from the command register; mem_wr_en = cmd_we.
  - On the clock edge, the winner's ack is set for the following cycle.
  - If cmd_we = 0, mem_rd is captured into that port's rdata.
  - Return to IDLE unconditionally; back-to-back grants are not possible.
  - No gnt is asserted in ACCESS.
- Arbitration, with both req high in IDLE:
  - Grant the port that did not win the previous grant.
  - The last-winner pointer resets to 1, so port 0 wins the first tie.
  - The pointer updates only on a grant.
  - A single requester is always granted, regardless of the pointer.
- mem_wr_en is 0 in every state except ACCESS with cmd_we = 1.
- mem_addr/mem_wd hold the last command-register value outside ACCESS.
- The losing port's rdata and ack are unaffected.
- Writes leave rdata unchanged.

## Timing
- Request sampled in IDLE at cycle N; gnt is high during N.
- Memory access in cycle N+1 (busy = 1).
- ack (and rdata for reads) valid in cycle N+2, for one cycle.
- Load latency from gnt to ack: 2 cycles. Maximum throughput: one access per 2 cycles.
- A requester may reassert req in cycle N+1; it is considered at the next IDLE (N+2) at the earliest.
- Reset values: state = IDLE, last-winner = 1, all gnt/ack = 0, rdata = 0, command register = 0, mem_wr_en = 0, mem_addr = 0, mem_wd = 0, busy = 0.
- Reset asserted during ACCESS:
  - mem_wr_en drops immediately.
  - The pending ack is cancelled and rdata is not updated.
- Requester dropping req before gnt: legal; the request is not latched.

## Configuration
- DATAMEM_ARB_RR_EN defined: round-robin as specified under Operation.
- DATAMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties.
  - The last-winner pointer is not implemented.
  - Port 1 can be starved indefinitely.

## Test plan
- Single read: m0 read addr 0xFF with mem_rd = 0x12345.
  - m0_gnt in cycle N, mem_addr = 0xFF with mem_wr_en = 0 in N+1.
  - m0_ack with m0_rdata = 0x12345 in N+2.
- Single write: m1 write addr 0x10, wd 0xDEADBEEF.
  - mem_wr_en = 1, mem_addr = 0x10, mem_wd = 0xDEADBEEF for exactly one cycle.
  - m1_ack in N+2; m1_rdata unchanged.
- Contention with RR: both ports requesting continuously.
  - Grants alternate 0, 1, 0, 1, with a gnt every 2 cycles.
  - Without the macro: all four grants go to port 0.
- Back-to-back: m0 write 0x20 := 0x5, then m0 read 0x20 with the memory model attached.
  - Read ack returns rdata = 0x5, 4 cycles after the first gnt.
- Reset mid-access: assert rst during ACCESS of a write.
  - mem_wr_en = 0 in the same cycle; no ack ever issued.
  - After release, the next tie goes to port 0.
- Idle: no requests for 10 cycles → no gnt, ack or mem_wr_en; busy = 0 throughout.
